jpeg_output_frame_ctrl: RTL
===========================

Name: jpeg_output_frame_ctrl

Overview:
Frame-level sequencer placed after the decoder's pixel output stage and ahead of the frame-buffer writer. The decoder emits pixels in whole 8x8 blocks, so the image is padded to a multiple of 8 in each direction. This block drops pixels outside width x height, forwards in-range pixels through a one-entry output register, and counts delivered pixels. It reports frame completion, or a short-frame error, to the host control logic.

Parameters:
COUNT_W, 32, width of the pixel counter and of the expected-pixel product (width*height)
TIMEOUT_CYCLES, 1048575, stall limit used only when the optional feature is compiled in

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
start_i  in  1  image start pulse (same pulse the decoder receives)
width_i  in  16  image width in pixels; sampled on start_i
height_i  in  16  image height in pixels; sampled on start_i
dec_idle_i  in  1  decoder output stage idle (high once its EOF marker has been consumed)
inport_valid_i  in  1  pixel valid from decoder
inport_x_i  in  16  pixel x
inport_y_i  in  16  pixel y
inport_rgb_i  in  24  {r,g,b}
inport_accept_o  out  1  pixel accepted
outport_valid_o  out  1  clipped pixel valid
outport_x_o  out  16  pixel x
outport_y_o  out  16  pixel y
outport_rgb_o  out  24  {r,g,b}
outport_accept_i  in  1  downstream accept
busy_o  out  1  state is RUN or DRAIN
done_o  out  1  one-cycle pulse on frame completion
error_o  out  1  sticky short-frame / timeout flag; cleared by start_i
pixel_count_o  out  COUNT_W  in-range pixels delivered downstream this frame

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; all outputs 0; width/height registers 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start_i.
  - RUN -> DRAIN when the in-range accepted count reaches width*height (computed as a COUNT_W-bit product; the upper bits of the 32-bit product are truncated when COUNT_W<32).
  - RUN -> DRAIN with error_o set when dec_idle_i is high, the count is still short, and no pixel is pending. dec_idle_i is ignored during the first 2 cycles after start_i.
  - DRAIN -> DONE when the output register is empty, or is emptying this cycle.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- start_i in any state, including mid-frame: the next state is RUN; count, error_o and outport_valid_o are cleared; the width/height registers are reloaded. start_i wins over every simultaneous transition. No done_o is issued for the aborted frame.
- Zero dimension (width_i==0 or height_i==0): RUN -> DRAIN -> DONE with no pixels forwarded and error_o=0. All input pixels are dropped.
- Handshake: space = !outport_valid_o || outport_accept_i.
  - In RUN: inport_accept_o = in_range ? space : 1. Out-of-range pixels are consumed and discarded.
  - In IDLE, DRAIN and DONE: inport_accept_o = 1 and pixels are discarded. This prevents a post-frame deadlock of the decoder.
- in_range = (inport_x_i < width) && (inport_y_i < height), unsigned compare.
- Output register: loads on in_range && inport_valid_i && space in RUN. Latency is 1 cycle from input accept to outport_valid_o. Data is held stable while valid && !accept.
- pixel_count_o increments on outport_valid_o && outport_accept_i. The frame-complete compare uses the accepted-input count, so DRAIN covers the final pixel still in the register.
- The counter saturates at all-ones and does not wrap.
- Simultaneous load and drain of the output register sustains 1 pixel/cycle throughput.

Optional Feature:
Macro JPEG_OUTPUT_FRAME_CTRL_TIMEOUT_EN.
- Defined: a stall counter runs in RUN and clears on any input accept or output transfer. When it reaches TIMEOUT_CYCLES it sets error_o and forces RUN -> DRAIN; any pixel in the output register is dropped (outport_valid_o cleared).
- Undefined: no counter and no timeout; RUN exits only through the count or dec_idle_i.

Decomposition:
- Shared package jpeg_output_pkg holds:
  - FSM state enum (2-bit);
  - pixel struct {x,y,rgb};
  - existing block-type constants (BLOCK_Y/CB/CR/EOF) and mode constants, reused so all output blocks share one definition.
- One sub-module is natural: jpeg_output_frame_ctrl_reg, the one-entry valid/accept pixel register with flush input.

Test Plan:
- 16x8 image; decoder sends 2 blocks x 64 pixels; outport_accept_i=1 -> 128 pixels out, raster order preserved; done_o pulses once; pixel_count_o=128; error_o=0.
- 10x10 image; blocks cover 16x16 (256 pixels) -> exactly 100 pixels out, all with x<10 and y<10; the 156 padding pixels are consumed; done_o=1 once.
- 8x8 image with outport_accept_i toggling 1/0 each cycle -> output data stable while stalled; 64 pixels out; done_o only after the last accept.
- 8x8 image; dec_idle_i asserted after 40 pixels -> DRAIN then DONE; error_o=1; pixel_count_o=40.
- start_i asserted mid-frame after 20 pixels with width 4, height 4 -> outport_valid_o drops next cycle; no done_o for the old frame; new frame completes with count 16.
- width_i=0 on start_i -> done_o within 3 cycles; no outport_valid_o; error_o=0. With the macro defined and TIMEOUT_CYCLES=16, stalling the input for 16 cycles sets error_o=1.

Source files
------------

// File: rtl/jpeg_output_pkg.sv
// Shared definitions for the JPEG decoder output stage.
// Holds the frame-sequencer state encoding, the pixel payload struct, the
// block-type and colour-mode constants shared by all output blocks, and a
// pixel clipping helper.
package jpeg_output_pkg;

    localparam int unsigned COORD_W = 16;
    localparam int unsigned RGB_W   = 24;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } frame_state_t;

    // Pixel payload carried on the output port
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [RGB_W-1:0]   rgb;
    } pixel_t;

    // Block types emitted by the entropy/IDCT stages
    localparam logic [1:0] BLOCK_Y   = 2'd0;
    localparam logic [1:0] BLOCK_CB  = 2'd1;
    localparam logic [1:0] BLOCK_CR  = 2'd2;
    localparam logic [1:0] BLOCK_EOF = 2'd3;

    // Colour sampling modes
    localparam logic [1:0] JPEG_MONOCHROME  = 2'd0;
    localparam logic [1:0] JPEG_YCBCR_444   = 2'd1;
    localparam logic [1:0] JPEG_YCBCR_420   = 2'd2;
    localparam logic [1:0] JPEG_UNSUPPORTED = 2'd3;

    // True when the pixel lies inside the visible (unpadded) image
    function automatic logic pixel_in_range(input pixel_t px,
                                            input logic [COORD_W-1:0] width,
                                            input logic [COORD_W-1:0] height);
        return (px.x < width) && (px.y < height);
    endfunction

endpackage

// File: rtl/jpeg_output_frame_ctrl_reg.sv
// One-entry valid/accept pixel register with flush.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-low reset
//   flush_i        drop any held pixel (highest priority)
//   load_i         capture data_i (caller only loads when space_c is high)
//   data_i         pixel to capture
//   accept_i       downstream accept
//   valid_o/data_o registered pixel output, held stable while stalled
//   space_c        register can take a pixel this cycle (combinational)
module jpeg_output_frame_ctrl_reg
    import jpeg_output_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   flush_i,
    input  logic   load_i,
    input  pixel_t data_i,
    input  logic   accept_i,
    output logic   valid_o,
    output pixel_t data_o,
    output logic   space_c
);

    // Load while draining keeps one pixel per cycle flowing
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
        end else if (accept_i) begin
            valid_o <= 1'b0;
        end
    end

    assign space_c = !valid_o || accept_i;

endmodule

// File: rtl/jpeg_output_frame_ctrl.sv
// Frame-level sequencer between the decoder pixel output and the frame-buffer
// writer. Clips the 8x8-padded pixel stream to width x height, forwards
// in-range pixels through a one-entry register, counts delivered pixels and
// reports frame completion or a short frame.
// Optional stall timeout: define JPEG_OUTPUT_FRAME_CTRL_TIMEOUT_EN.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   start_i                 image start; width_i/height_i sampled here
//   dec_idle_i              decoder output stage has consumed its EOF
//   inport_*                pixel stream from the decoder
//   outport_*               clipped pixel stream to the frame buffer
//   busy_o                  frame in RUN or DRAIN
//   done_o                  one-cycle frame-complete pulse
//   error_o                 sticky short-frame / timeout flag
//   pixel_count_o           pixels delivered downstream this frame
module jpeg_output_frame_ctrl
    import jpeg_output_pkg::*;
#(
    parameter int unsigned COUNT_W        = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [15:0]        width_i,
    input  logic [15:0]        height_i,
    input  logic               dec_idle_i,
    input  logic               inport_valid_i,
    input  logic [15:0]        inport_x_i,
    input  logic [15:0]        inport_y_i,
    input  logic [23:0]        inport_rgb_i,
    output logic               inport_accept_o,
    output logic               outport_valid_o,
    output logic [15:0]        outport_x_o,
    output logic [15:0]        outport_y_o,
    output logic [23:0]        outport_rgb_o,
    input  logic               outport_accept_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    output logic [COUNT_W-1:0] pixel_count_o
);

    localparam logic [1:0] GUARD_CYCLES = 2'd2;

    frame_state_t       state_q, state_d;
    logic [15:0]        width_q, height_q;
    logic [COUNT_W-1:0] acc_count_q, acc_count_d;
    logic [COUNT_W-1:0] pix_count_q, pix_count_d;
    logic [COUNT_W-1:0] expected;
    logic [31:0]        area;
    logic [1:0]         guard_q, guard_d;
    logic               error_q, error_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    pixel_t             in_px, out_px;
    logic               out_valid;
    logic               space;
    logic               in_range;
    logic               load;
    logic               flush;
    logic               accept_c;
    logic               out_xfer;
    logic               timeout_hit;

    assign in_px    = '{x: inport_x_i, y: inport_y_i, rgb: inport_rgb_i};
    assign in_range = pixel_in_range(in_px, width_q, height_q);
    assign out_xfer = out_valid && outport_accept_i;

    // Expected pixel total; upper product bits drop when COUNT_W < 32
    assign area     = 32'(width_q) * 32'(height_q);
    assign expected = COUNT_W'(area);

`ifdef JPEG_OUTPUT_FRAME_CTRL_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic               in_xfer;
    logic [STALL_W-1:0] stall_q;

    assign in_xfer = inport_valid_i && accept_c;

    // Counts RUN cycles with no traffic on either side
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_q <= '0;
        end else if (start_i || (state_q != ST_RUN) || in_xfer || out_xfer) begin
            stall_q <= '0;
        end else if (!timeout_hit) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign timeout_hit = (state_q == ST_RUN) && (stall_q == STALL_W'(TIMEOUT_CYCLES));
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES == 32'd0);
    assign timeout_hit    = 1'b0;
`endif

    // State and status registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            width_q     <= '0;
            height_q    <= '0;
            acc_count_q <= '0;
            pix_count_q <= '0;
            guard_q     <= '0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_count_q <= acc_count_d;
            pix_count_q <= pix_count_d;
            guard_q     <= guard_d;
            error_q     <= error_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            if (start_i) begin
                width_q  <= width_i;
                height_q <= height_i;
            end
        end
    end

    // Next-state, handshake and counter logic
    always_comb begin
        state_d     = state_q;
        acc_count_d = acc_count_q;
        pix_count_d = pix_count_q;
        guard_d     = guard_q;
        error_d     = error_q;
        load        = 1'b0;
        flush       = 1'b0;
        accept_c    = 1'b1;

        if (out_xfer && (pix_count_q != '1)) begin
            pix_count_d = pix_count_q + COUNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                // Out-of-range padding is always consumed and discarded
                accept_c = in_range ? space : 1'b1;
                load     = inport_valid_i && in_range && space;
                if (load && (acc_count_q != '1)) begin
                    acc_count_d = acc_count_q + COUNT_W'(1);
                end
                if (guard_q != 2'd0) begin
                    guard_d = guard_q - 2'd1;
                end
                if (timeout_hit) begin
                    state_d     = ST_DRAIN;
                    error_d     = 1'b1;
                    flush       = 1'b1;
                    load        = 1'b0;
                    acc_count_d = acc_count_q;
                end else if (acc_count_d == expected) begin
                    state_d = ST_DRAIN;
                end else if ((guard_q == 2'd0) && dec_idle_i && !inport_valid_i) begin
                    // Decoder finished early: short frame
                    state_d = ST_DRAIN;
                    error_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (space) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new image restarts from any state and abandons the old frame
        if (start_i) begin
            state_d     = ST_RUN;
            acc_count_d = '0;
            pix_count_d = '0;
            error_d     = 1'b0;
            guard_d     = GUARD_CYCLES;
            load        = 1'b0;
            flush       = 1'b1;
        end

        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    jpeg_output_frame_ctrl_reg u_out_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush_i  (flush),
        .load_i   (load),
        .data_i   (in_px),
        .accept_i (outport_accept_i),
        .valid_o  (out_valid),
        .data_o   (out_px),
        .space_c  (space)
    );

    assign inport_accept_o = accept_c;
    assign outport_valid_o = out_valid;
    assign outport_x_o     = out_px.x;
    assign outport_y_o     = out_px.y;
    assign outport_rgb_o   = out_px.rgb;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign error_o         = error_q;
    assign pixel_count_o   = pix_count_q;

endmodule
